// File: rtl/battle_turn_controller_pkg.sv
// Shared types for the battle turn controller: attack codes, FSM states,
// engine field widths and the enemy attack fallback rule.
package battle_turn_controller_pkg;

    localparam int HP_W    = 8;
    localparam int STOCK_W = 5;

    typedef enum logic [1:0] {
        ATK_P = 2'b00,
        ATK_K = 2'b01,
        ATK_B = 2'b10,
        ATK_S = 2'b11
    } attack_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P_WAIT,
        ST_P_STRIKE,
        ST_P_SETTLE,
        ST_E_THINK,
        ST_E_STRIKE,
        ST_E_SETTLE,
        ST_DONE
    } state_t;

    // A sword fallback yields B, which must itself pass the bat stock test.
    function automatic attack_t enemy_attack(input attack_t raw, input logic finish,
                                             input logic sword_empty, input logic bat_empty);
        attack_t pick;
        pick = raw;
        if (finish) begin
            pick = ATK_P;
        end else begin
            if (pick == ATK_S && sword_empty) pick = ATK_B;
            if (pick == ATK_B && bat_empty) pick = ATK_K;
        end
        return pick;
    endfunction

endpackage

// File: rtl/battle_turn_controller_lfsr8.sv
// Seeded, free-running 8-bit Fibonacci LFSR (taps 8,6,5,4).
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (rst) value <= SEED;
        else     value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end

endmodule

// File: rtl/battle_turn_controller.sv
// Sequences one combat encounter: player key -> strike -> settle -> enemy think
// -> strike -> settle, ending when the engine reports a zero HP.
module battle_turn_controller
    import battle_turn_controller_pkg::*;
#(
    parameter int         ENEMY_DELAY   = 16,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] LFSR_SEED     = 8'hA5,
    parameter logic [7:0] FINISH_HP     = 8'd12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               battle_start,
    input  logic               key_valid,
    input  logic [1:0]         key_choice,
    input  logic [HP_W-1:0]    player_HP,
    input  logic [HP_W-1:0]    enemy_HP,
    input  logic [STOCK_W-1:0] player_remained_sword,
    input  logic [STOCK_W-1:0] player_remained_baseballbat,
    input  logic [STOCK_W-1:0] enemy_remained_sword,
    input  logic [STOCK_W-1:0] enemy_remained_baseballbat,
    output logic               player_turn,
    output logic               attacker_turn,
    output logic [1:0]         player_choice,
    output logic [1:0]         enemy_choice,
    output logic               key_reject,
    output logic               battle_active,
    output logic               player_won,
    output logic               enemy_won,
    output logic [7:0]         turn_count
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] THINK_LAST  = 16'(ENEMY_DELAY - 1);

    state_t      state, next_state;
    logic [15:0] wait_cnt, wait_cnt_next;
    logic [7:0]  lfsr_value;
    logic        unused_lfsr_bits;
    logic        key_refused, accept, reject, pick, count_strike, set_pwon, set_ewon;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[7:2];
    assign battle_active    = (state != ST_IDLE) && (state != ST_DONE);
    assign key_refused = (key_choice == ATK_S && player_remained_sword == '0) ||
                         (key_choice == ATK_B && player_remained_baseballbat == '0);

    always_comb begin
        next_state    = state;
        wait_cnt_next = '0;
        accept        = 1'b0;
        reject        = 1'b0;
        pick          = 1'b0;
        count_strike  = 1'b0;
        set_pwon      = 1'b0;
        set_ewon      = 1'b0;
        player_turn   = 1'b0;
        attacker_turn = 1'b0;
        // Losing battle_start aborts everything, including a strike due this cycle.
        if (state != ST_IDLE && !battle_start) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (battle_start) next_state = ST_P_WAIT;
                ST_P_WAIT: begin
                    if (key_valid) begin
                        if (key_refused) begin
                            reject = 1'b1;
                        end else begin
                            accept     = 1'b1;
                            next_state = ST_P_STRIKE;
                        end
                    end
                end
                ST_P_STRIKE: begin
                    player_turn  = !rst;
                    count_strike = 1'b1;
                    next_state   = ST_P_SETTLE;
                end
                ST_P_SETTLE, ST_E_SETTLE: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        if (enemy_HP == '0) begin
                            set_pwon   = 1'b1;
                            next_state = ST_DONE;
                        end else if (player_HP == '0) begin
                            set_ewon   = 1'b1;
                            next_state = ST_DONE;
                        end else begin
                            next_state = (state == ST_P_SETTLE) ? ST_E_THINK : ST_P_WAIT;
                        end
                    end else begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                end
                ST_E_THINK: begin
                    if (wait_cnt == THINK_LAST) begin
                        pick       = 1'b1;
                        next_state = ST_E_STRIKE;
                    end else begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                end
                ST_E_STRIKE: begin
                    attacker_turn = !rst;
                    count_strike  = 1'b1;
                    next_state    = ST_E_SETTLE;
                end
                ST_DONE: next_state = ST_DONE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            player_choice <= 2'b00;
            enemy_choice  <= 2'b00;
            key_reject    <= 1'b0;
            player_won    <= 1'b0;
            enemy_won     <= 1'b0;
            turn_count    <= '0;
        end else begin
            state      <= next_state;
            wait_cnt   <= wait_cnt_next;
            key_reject <= reject;
            if (accept) player_choice <= key_choice;
            if (pick) begin
                enemy_choice <= enemy_attack(attack_t'(lfsr_value[1:0]),
                                             player_HP <= FINISH_HP,
                                             enemy_remained_sword == '0,
                                             enemy_remained_baseballbat == '0);
            end
            if (state == ST_IDLE) begin
                player_won <= 1'b0;
                enemy_won  <= 1'b0;
                turn_count <= '0;
            end else begin
                if (set_pwon) player_won <= 1'b1;
                if (set_ewon) enemy_won <= 1'b1;
                if (count_strike && turn_count != 8'hFF) turn_count <= turn_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_battle_turn_controller.sv
// Randomized battles against a cycle-timed reference of the turn rules; strike and
// reject pulses are predicted into queues and matched by an independent monitor.
module tb_battle_turn_controller;

    localparam int         ENEMY_DELAY   = 16;
    localparam int         SETTLE_CYCLES = 2;
    localparam logic [7:0] SEED          = 8'hA5;
    localparam logic [7:0] FINISH_HP     = 8'd12;
    localparam int         W             = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       battle_start = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_choice = 2'b00;
    logic [7:0] player_hp = 8'd100;
    logic [7:0] enemy_hp = 8'd100;
    logic [4:0] p_sword = 5'd3, p_bat = 5'd3, e_sword = 5'd3, e_bat = 5'd3;

    logic       player_turn, attacker_turn, key_reject, battle_active, player_won, enemy_won;
    logic [1:0] player_choice, enemy_choice;
    logic [7:0] turn_count;

    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Entries are {cycle[19:0], turn_count before the strike, choice}.
    logic [W-1:0] exp_p[$];
    logic [W-1:0] exp_e[$];
    logic [W-1:0] exp_r[$];

    battle_turn_controller #(
        .ENEMY_DELAY   (ENEMY_DELAY),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LFSR_SEED     (SEED),
        .FINISH_HP     (FINISH_HP)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .battle_start                (battle_start),
        .key_valid                   (key_valid),
        .key_choice                  (key_choice),
        .player_HP                   (player_hp),
        .enemy_HP                    (enemy_hp),
        .player_remained_sword       (p_sword),
        .player_remained_baseballbat (p_bat),
        .enemy_remained_sword        (e_sword),
        .enemy_remained_baseballbat  (e_bat),
        .player_turn                 (player_turn),
        .attacker_turn               (attacker_turn),
        .player_choice               (player_choice),
        .enemy_choice                (enemy_choice),
        .key_reject                  (key_reject),
        .battle_active               (battle_active),
        .player_won                  (player_won),
        .enemy_won                   (enemy_won),
        .turn_count                  (turn_count)
    );

    // ---------------- clock / reset / cycle index ----------------
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] pack(input int unsigned c, input logic [7:0] t, input logic [1:0] ch);
        logic [31:0] cv;
        cv = c;
        return {cv[19:0], t, ch};
    endfunction

    // LFSR contents during cycle n after reset release: the seed shifted n times.
    function automatic logic [7:0] lfsr_after(input int unsigned n);
        logic [7:0] l;
        l = SEED;
        for (int unsigned i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    function automatic logic [1:0] enemy_pick(input logic [7:0] l, input logic [7:0] php,
                                              input logic [4:0] esw, input logic [4:0] ebat);
        logic [1:0] c;
        c = l[1:0];
        if (php <= FINISH_HP) return 2'd0;
        if (c == 2'd3 && esw == 0) c = 2'd2;
        if (c == 2'd2 && ebat == 0) c = 2'd1;
        return c;
    endfunction

    function automatic bit refused(input logic [1:0] c, input logic [4:0] sw, input logic [4:0] bat);
        return (c == 2'd3 && sw == 0) || (c == 2'd2 && bat == 0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] t);
        return (t == 8'hFF) ? t : t + 8'd1;
    endfunction

    function automatic logic [4:0] rand_stock();
        return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    function automatic logic [7:0] rand_hp();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'd0;
        if (r <= 2) return 8'($urandom_range(1, 12));
        return 8'($urandom_range(13, 255));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int unsigned target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("sync_cycle", cyc, target);
    endtask

    task automatic press(input logic [1:0] c);
        key_valid  = 1'b1;
        key_choice = c;
        @(negedge clk);
        key_valid  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, battle_active, 0);
        check({tag, "_turn_count"}, turn_count, 0);
        check({tag, "_player_choice"}, player_choice, 0);
        check({tag, "_enemy_choice"}, enemy_choice, 0);
        check({tag, "_player_won"}, player_won, 0);
        check({tag, "_enemy_won"}, enemy_won, 0);
        check({tag, "_player_turn"}, player_turn, 0);
        check({tag, "_attacker_turn"}, attacker_turn, 0);
        check({tag, "_key_reject"}, key_reject, 0);
    endtask

    task automatic finish_battle(input int unsigned endc, input logic [7:0] tc);
        logic pw, ew;
        pw = (enemy_hp == 0);
        ew = !pw && (player_hp == 0);
        wait_cyc(endc + 1);
        check("done_active", battle_active, 0);
        check("done_player_won", player_won, pw);
        check("done_enemy_won", enemy_won, ew);
        check("done_turn_count", turn_count, tc);
        @(negedge clk);
        check("sticky_player_won", player_won, pw);
        check("sticky_enemy_won", enemy_won, ew);
        battle_start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_player_won", player_won, 0);
        check("idle_enemy_won", enemy_won, 0);
        check("idle_turn_count", turn_count, 0);
    endtask

    task automatic run_battle(input int max_rounds, input bit long_mode);
        logic [7:0]  tc, lv;
        logic [1:0]  c, ec;
        int unsigned s, pk, a, roll;
        int          tries;
        tc = 8'd0;
        e_sword = rand_stock();
        e_bat   = rand_stock();
        battle_start = 1'b1;
        @(negedge clk);
        check("start_active", battle_active, 1);
        for (int r = 0; r < max_rounds; r++) begin
            if (long_mode) begin
                player_hp = 8'($urandom_range(50, 200));
                enemy_hp  = 8'($urandom_range(50, 200));
            end else begin
                player_hp = rand_hp();
                enemy_hp  = rand_hp();
            end
            p_sword = rand_stock();
            p_bat   = rand_stock();
            tries = 0;
            c = 2'($urandom_range(0, 3));
            while (refused(c, p_sword, p_bat) && tries < 3) begin
                exp_r.push_back(pack(cyc + 1, 8'd0, 2'd0));
                press(c);
                tries++;
                c = 2'($urandom_range(0, 3));
            end
            if (refused(c, p_sword, p_bat)) c = 2'($urandom_range(0, 1));
            s = cyc + 1;
            exp_p.push_back(pack(s, tc, c));
            tc = sat_inc(tc);
            press(c);
            if (enemy_hp == 0 || player_hp == 0) begin
                finish_battle(s + SETTLE_CYCLES, tc);
                return;
            end
            pk = s + SETTLE_CYCLES + ENEMY_DELAY;
            lv = lfsr_after(pk);
            ec = enemy_pick(lv, player_hp, e_sword, e_bat);
            roll = long_mode ? 99 : $urandom_range(0, 19);
            if (roll == 0) begin
                // Abort while the enemy is thinking: no enemy strike may follow.
                wait_cyc(s + SETTLE_CYCLES + 3);
                battle_start = 1'b0;
                @(negedge clk);
                check("abort_active", battle_active, 0);
                check("abort_player_won", player_won, 0);
                check("abort_enemy_won", enemy_won, 0);
                repeat (SETTLE_CYCLES + ENEMY_DELAY + 4) @(negedge clk);
                return;
            end
            if (roll == 1) begin
                wait_cyc(s + SETTLE_CYCLES + 3);
                rst = 1'b1;
                battle_start = 1'b0;
                @(negedge clk);
                check_all_zero("midreset");
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            a = pk + 1;
            exp_e.push_back(pack(a, tc, ec));
            tc = sat_inc(tc);
            // A key while the enemy thinks must be ignored silently.
            wait_cyc(s + SETTLE_CYCLES + 1);
            press(2'($urandom_range(0, 3)));
            wait_cyc(a);
            if (!long_mode) begin
                roll = $urandom_range(0, 15);
                if (roll == 0) player_hp = 8'd0;
                if (roll == 1) enemy_hp = 8'd0;
                if (roll == 2) begin
                    player_hp = 8'd0;
                    enemy_hp  = 8'd0;
                end
            end
            if (enemy_hp == 0 || player_hp == 0) begin
                finish_battle(a + SETTLE_CYCLES, tc);
                return;
            end
            wait_cyc(a + SETTLE_CYCLES + 1);
        end
        battle_start = 1'b0;
        @(negedge clk);
        check("budget_abort_active", battle_active, 0);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic [31:0]  cv;
        bit           hit;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                cv = cyc;
                check("pulses_exclusive", player_turn & attacker_turn, 0);

                hit = (exp_p.size() > 0) && (exp_p[0][29:10] == cv[19:0]);
                check("player_turn", player_turn, hit);
                if (hit) begin
                    e = exp_p.pop_front();
                    check("player_choice", player_choice, e[1:0]);
                    check("turn_count_at_player_strike", turn_count, e[9:2]);
                end

                hit = (exp_e.size() > 0) && (exp_e[0][29:10] == cv[19:0]);
                check("attacker_turn", attacker_turn, hit);
                if (hit) begin
                    e = exp_e.pop_front();
                    check("enemy_choice", enemy_choice, e[1:0]);
                    check("turn_count_at_enemy_strike", turn_count, e[9:2]);
                end

                hit = (exp_r.size() > 0) && (exp_r[0][29:10] == cv[19:0]);
                check("key_reject", key_reject, hit);
                if (hit) void'(exp_r.pop_front());
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 40; b++) run_battle($urandom_range(1, 6), 1'b0);
        run_battle(130, 1'b1);
        repeat (5) @(negedge clk);
        check("pending_player_strikes", exp_p.size(), 0);
        check("pending_enemy_strikes", exp_e.size(), 0);
        check("pending_rejects", exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/battle_turn_controller.md
Name: battle_turn_controller

Overview:
- Sequences one combat encounter for the combat engine.
- Alternates player and enemy turns and issues one-cycle strike pulses (player_turn, attacker_turn) with the latched attack choice.
- Picks the enemy attack from an LFSR, respecting enemy weapon stock.
- Detects the end of battle from engine HP after each strike settles.
- Sits between the keypad/collision logic and the combat engine.

Parameters:
- ENEMY_DELAY, 16: cycles the enemy "thinks" before striking (must be ≥1).
- SETTLE_CYCLES, 2: cycles waited after a strike pulse before HP is sampled (must be ≥1).
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.
- FINISH_HP, 8'd12: if player_HP ≤ this, the enemy always picks punch (P).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- battle_start  in  1  level; high while the collision/encounter is in progress
- key_valid  in  1  one-cycle pulse; player pressed an attack key
- key_choice  in  2  attack code: P=00, K=01, B=10, S=11
- player_HP  in  8  engine player health
- enemy_HP  in  8  engine enemy health
- player_remained_sword  in  5  engine stock
- player_remained_baseballbat  in  5  engine stock
- enemy_remained_sword  in  5  engine stock
- enemy_remained_baseballbat  in  5  engine stock
- player_turn  out  1  one-cycle strike pulse to the engine
- attacker_turn  out  1  one-cycle enemy strike pulse to the engine
- player_choice  out  2  latched player attack; held until the next accepted key
- enemy_choice  out  2  latched enemy attack; held until the next enemy pick
- key_reject  out  1  one-cycle pulse; key refused because the weapon is exhausted
- battle_active  out  1  high in any state other than IDLE or DONE
- player_won  out  1  sticky in DONE
- enemy_won  out  1  sticky in DONE
- turn_count  out  8  completed strikes (player + enemy), saturating at 255

Behaviour:
- Reset values:
  - All outputs 0; choices 00.
  - FSM in IDLE, LFSR = LFSR_SEED, wait counter 0.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every cycle, including IDLE.
- States: IDLE, P_WAIT, P_STRIKE, P_SETTLE, E_THINK, E_STRIKE, E_SETTLE, DONE.
- IDLE:
  - On battle_start=1, go to P_WAIT.
  - Clear turn_count, player_won and enemy_won.
- P_WAIT, when key_valid=1:
  - Reject if key_choice=S and player sword stock=0, or key_choice=B and player bat stock=0.
  - On reject: pulse key_reject, stay in P_WAIT.
  - Otherwise latch player_choice and go to P_STRIKE.
  - key_valid outside P_WAIT is ignored and produces no reject.
- P_STRIKE:
  - player_turn=1 for exactly this one cycle.
  - Increment turn_count (saturating), go to P_SETTLE.
- P_SETTLE:
  - Count SETTLE_CYCLES cycles, then sample HP in the final cycle.
  - enemy_HP=0 → DONE with player_won=1.
  - Else player_HP=0 → DONE with enemy_won=1.
  - Else → E_THINK.
- E_THINK:
  - Count ENEMY_DELAY cycles.
  - In the final cycle, pick enemy_choice = LFSR[1:0], then apply fallbacks in order:
    - player_HP ≤ FINISH_HP → P.
    - S with enemy sword stock=0 → B.
    - B with enemy bat stock=0 → K. This also applies to a B produced by the S fallback.
  - Go to E_STRIKE.
- E_STRIKE:
  - attacker_turn=1 for one cycle, increment turn_count, go to E_SETTLE.
- E_SETTLE:
  - Same HP check as P_SETTLE (enemy_HP=0 checked first).
  - Otherwise → P_WAIT.
- DONE:
  - player_won or enemy_won held.
  - Return to IDLE when battle_start=0.
- Abort:
  - battle_start=0 in any non-IDLE state → IDLE next cycle; no strike pulse issued that cycle.
  - Won flags are cleared unless the FSM is in DONE.
- Simultaneous zero HP: player_won takes priority.
- Never assert player_turn and attacker_turn in the same cycle.
- rst mid-battle: immediate return to reset values; a pending pulse is suppressed.

Decomposition:
- Shared package:
  - Attack codes P/K/B/S.
  - FSM state encoding.
  - HP and stock widths (8 and 5).
- Sub-module: lfsr8 (seeded, free-running, 8-bit), reused later for engine damage variance.

Test Plan:
- Reset, battle_start=1, key_valid with K:
  - P_STRIKE one cycle after the key; player_turn high exactly 1 cycle; player_choice=01; turn_count=1.
- Player sword stock=0, key S:
  - key_reject pulse; no player_turn; FSM stays in P_WAIT.
  - A following key P is accepted.
- After the player strike with enemy_HP=40, player_HP=100:
  - attacker_turn rises exactly SETTLE_CYCLES+ENEMY_DELAY+1 cycles after player_turn.
- Enemy stock: force LFSR[1:0]=11 with enemy sword=0 and bat=0 → enemy_choice=01 (K).
- Force player_HP=10 → enemy_choice=00 regardless of LFSR.
- Drive enemy_HP=0 during P_SETTLE → DONE with player_won=1; then battle_start=0 → IDLE with flags cleared.
- Both HP=0 → player_won=1, enemy_won=0.
- Drop battle_start in E_THINK → IDLE; no attacker_turn pulse.
